mac_accum: RTL and testbench

Downstream consumer of the sequential Booth multiplier. It takes each signed product on the multiplier's one-cycle `done` strobe and accumulates a fixed-length group of `LEN` products, forming a dot product. The accumulator is sign-extended and saturating. Each completed sum is presented through a one-entry valid/ready output register. The multiplier cannot be back-pressured, so a result that cannot be buffered is dropped and flagged.

---
 rtl/mac_pkg.sv | 45 ++++
 rtl/mac_accum_if.sv | 28 ++
 rtl/mac_accum_sat_add.sv | 33 +++
 rtl/mac_accum.sv | 96 +++++++++
 tb/tb_mac_accum.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types, defaults and arithmetic helpers for the MAC accumulator.
package mac_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int ACC_W_DEF = 24;
    localparam int LEN_DEF   = 8;

    // Helpers work at a fixed wide width; callers pass their real width.
    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    // Which bound, if any, a wide sum crosses for a given accumulator width.
    typedef struct packed {
        logic hi;
        logic lo;
    } sat_dir_t;

    function automatic wide_t acc_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t acc_min(input int w);
        return -acc_max(w) - wide_t'(1);
    endfunction

    localparam wide_t ACC_MAX = acc_max(ACC_W_DEF);
    localparam wide_t ACC_MIN = acc_min(ACC_W_DEF);

    // Sign-extend the low w bits of v to the full wide width.
    function automatic wide_t sign_ext(input logic [MAX_W-1:0] v, input int w);
        wide_t t;
        t = $signed(v << (MAX_W - w));
        return t >>> (MAX_W - w);
    endfunction

    // Report whether s lies above or below the signed range of a w-bit value.
    function automatic sat_dir_t sat_dir(input wide_t s, input int w);
        sat_dir_t d;
        d.hi = (s > acc_max(w));
        d.lo = (s < acc_min(w));
        return d;
    endfunction

endpackage

// File: rtl/mac_accum_if.sv
// Product input, group control and result handshake of the MAC accumulator.
interface mac_accum_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 24,
    parameter int LEN   = 8
);
    logic                          prod_valid;
    logic signed [2*WIDTH-1:0]     prod;
    logic                          clear;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACC_W-1:0]       out_sum;
    logic                          out_sat;
    logic                          overrun;
    logic [$clog2(LEN+1)-1:0]      count;

    // Producer/consumer side (multiplier plus result sink).
    modport master (
        output prod_valid, prod, clear, out_ready,
        input  out_valid, out_sum, out_sat, overrun, count
    );

    // Accumulator side.
    modport slave (
        input  prod_valid, prod, clear, out_ready,
        output out_valid, out_sum, out_sat, overrun, count
    );
endinterface

// File: rtl/mac_accum_sat_add.sv
// Signed ACC_W add that clamps to the representable range and flags clamping.
module sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    wide_t    a_w;
    wide_t    b_w;
    wide_t    raw;
    sat_dir_t dir;

    // Add with headroom, then clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
    always_comb begin
        a_w = sign_ext({{(MAX_W-ACC_W){1'b0}}, a}, ACC_W);
        b_w = sign_ext({{(MAX_W-ACC_W){1'b0}}, b}, ACC_W);
        raw = a_w + b_w;
        dir = sat_dir(raw, ACC_W);
        sum = raw[ACC_W-1:0];
        if (dir.hi) begin
            sum = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (dir.lo) begin
            sum = {1'b1, {(ACC_W-1){1'b0}}};
        end
        ovf = dir.hi | dir.lo;
    end

endmodule

// File: rtl/mac_accum.sv
// Accumulates fixed-length groups of signed products into saturating dot
// products, presented through a one-entry valid/ready result register.
module mac_accum
    import mac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN   = LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    mac_accum_if.slave bus
);

    localparam int CNT_W     = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int CNT_OUT_W = $clog2(LEN + 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] add_sum;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_eff;
    logic                    grp_sat;
    logic                    add_ovf;
    logic                    sat_nxt;
    logic                    group_start;
    logic                    group_last;
    logic                    can_load;
    logic                    out_valid_q;
    logic                    out_sat_q;
    logic                    overrun_q;

    assign prod_ext = ACC_W'(bus.prod);

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // A clear coinciding with a product makes that product element 0 of a new
    // group, so the effective count and start condition fold clear in first.
    always_comb begin
        cnt_eff     = bus.clear ? '0 : cnt;
        group_start = (cnt_eff == '0);
        group_last  = (cnt_eff == CNT_W'(LEN - 1));
        acc_nxt     = group_start ? prod_ext : add_sum;
        sat_nxt     = group_start ? 1'b0 : (grp_sat | add_ovf);
        can_load    = !out_valid_q || bus.out_ready;
    end

    // Group accumulation, result register load/consume and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            grp_sat     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bus.prod_valid) begin
                acc     <= acc_nxt;
                grp_sat <= sat_nxt;
                cnt     <= group_last ? '0 : cnt_eff + 1'b1;
                if (group_last) begin
                    if (can_load) begin
                        out_valid_q <= 1'b1;
                        out_sum_q   <= acc_nxt;
                        out_sat_q   <= sat_nxt;
                    end else begin
                        overrun_q   <= 1'b1;
                    end
                end
            end else if (bus.clear) begin
                acc     <= '0;
                cnt     <= '0;
                grp_sat <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.overrun   = overrun_q;
    assign bus.count     = CNT_OUT_W'(cnt);

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: three configurations driven with directed vectors,
// checked every cycle against a behavioural model plus literal expectations.
module tb_mac_accum;

    typedef struct {
        longint acc;
        int     cnt;
        bit     gsat;
        bit     vld;
        longint sum;
        bit     osat;
        bit     ov;
    } mst_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rs  [3];
    logic               pv  [3];
    logic signed [15:0] pr  [3];
    logic               clr [3];
    logic               rdy [3];

    logic   o_vld [3];
    logic   o_sat [3];
    logic   o_ov  [3];
    longint o_sum [3];
    int     o_cnt [3];

    mst_t st [3];
    int   checks = 0;
    int   errors = 0;

    function automatic int len_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 8 : 2;
    endfunction

    function automatic int accw_of(input int i);
        return (i == 1) ? 18 : 24;
    endfunction

    // One cycle of the dot-product rules applied to plain integers.
    function automatic mst_t mstep(input mst_t s, input bit r, input bit v,
                                   input longint p, input bit c, input bit rd,
                                   input int len, input int accw);
        mst_t   n;
        longint mx;
        longint mn;
        longint t;
        bit     taken;
        n  = s;
        mx = (longint'(1) <<< (accw - 1)) - 1;
        mn = -mx - 1;
        if (r) begin
            n.acc = 0; n.cnt = 0; n.gsat = 0; n.vld = 0;
            n.sum = 0; n.osat = 0; n.ov = 0;
            return n;
        end
        taken = s.vld && rd;
        if (taken) n.vld = 0;
        if (c) begin
            n.acc = 0; n.cnt = 0; n.gsat = 0;
        end
        if (v) begin
            if (n.cnt == 0) begin
                n.acc  = p;
                n.gsat = 0;
            end else begin
                t = n.acc + p;
                if (t > mx) begin
                    t = mx; n.gsat = 1;
                end else if (t < mn) begin
                    t = mn; n.gsat = 1;
                end
                n.acc = t;
            end
            n.cnt = n.cnt + 1;
            if (n.cnt == len) begin
                n.cnt = 0;
                if (!s.vld || taken) begin
                    n.vld = 1; n.sum = n.acc; n.osat = n.gsat;
                end else begin
                    n.ov = 1;
                end
            end
        end
        return n;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = len_of(g);
        localparam int A = accw_of(g);

        mac_accum_if #(.WIDTH(8), .ACC_W(A), .LEN(L)) bus ();

        assign bus.prod_valid = pv[g];
        assign bus.prod       = pr[g];
        assign bus.clear      = clr[g];
        assign bus.out_ready  = rdy[g];

        mac_accum #(.WIDTH(8), .ACC_W(A), .LEN(L)) dut (
            .clk (clk),
            .rst (rs[g]),
            .bus (bus.slave)
        );

        assign o_vld[g] = bus.out_valid;
        assign o_sat[g] = bus.out_sat;
        assign o_ov[g]  = bus.overrun;
        assign o_sum[g] = longint'(bus.out_sum);
        assign o_cnt[g] = int'(bus.count);
    end

    // Advance the reference model on every clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            st[i] <= mstep(st[i], rs[i], pv[i], longint'(pr[i]), clr[i],
                           rdy[i], len_of(i), accw_of(i));
        end
    end

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 3; i++) begin
            chk("out_valid", i, longint'(o_vld[i]), longint'(st[i].vld));
            chk("out_sum",   i, o_sum[i],           st[i].sum);
            chk("out_sat",   i, longint'(o_sat[i]), longint'(st[i].osat));
            chk("overrun",   i, longint'(o_ov[i]),  longint'(st[i].ov));
            chk("count",     i, longint'(o_cnt[i]), longint'(st[i].cnt));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic feed(input int i, input longint p);
        pv[i] = 1'b1;
        pr[i] = 16'(p);
        step();
        pv[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 3; i++) begin
            pv[i]  = 1'b0;
            clr[i] = 1'b0;
        end
        repeat (n) step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rs[i] = 1'b1; pv[i] = 1'b0; pr[i] = '0; clr[i] = 1'b0; rdy[i] = 1'b1;
        end
        idle(2);
        for (int i = 0; i < 3; i++) rs[i] = 1'b0;
        chk("rst_valid", 0, longint'(o_vld[0]), 0);
        chk("rst_sum",   0, o_sum[0],           0);
        chk("rst_ovr",   0, longint'(o_ov[0]),  0);
        chk("rst_count", 0, longint'(o_cnt[0]), 0);

        // LEN=4 basic dot product
        feed(0, 3);    chk("t1_cnt1", 0, longint'(o_cnt[0]), 1);
        feed(0, -5);   chk("t1_cnt2", 0, longint'(o_cnt[0]), 2);
        feed(0, 100);  chk("t1_cnt3", 0, longint'(o_cnt[0]), 3);
        feed(0, -128);
        chk("t1_cnt0",  0, longint'(o_cnt[0]), 0);
        chk("t1_valid", 0, longint'(o_vld[0]), 1);
        chk("t1_sum",   0, o_sum[0],           -30);
        chk("t1_sat",   0, longint'(o_sat[0]), 0);
        idle(1);
        chk("t1_drop",  0, longint'(o_vld[0]), 0);

        // clear together with a product starts a new group
        feed(0, 50);
        feed(0, 60);
        clr[0] = 1'b1;
        feed(0, 7);
        clr[0] = 1'b0;
        chk("t5_cnt", 0, longint'(o_cnt[0]), 1);
        feed(0, 1);
        feed(0, 1);
        feed(0, 1);
        chk("t5_valid", 0, longint'(o_vld[0]), 1);
        chk("t5_sum",   0, o_sum[0],           10);
        idle(1);

        // reset mid-group
        feed(0, 9);
        feed(0, 9);
        feed(0, 9);
        chk("t6_cnt3", 0, longint'(o_cnt[0]), 3);
        rs[0] = 1'b1;
        idle(1);
        rs[0] = 1'b0;
        chk("t6_valid", 0, longint'(o_vld[0]), 0);
        chk("t6_sum",   0, o_sum[0],           0);
        chk("t6_count", 0, longint'(o_cnt[0]), 0);
        for (int k = 0; k < 4; k++) feed(0, 2);
        chk("t6_sum8",  0, o_sum[0],           8);
        chk("t6_vld8",  0, longint'(o_vld[0]), 1);
        idle(1);

        // LEN=8, ACC_W=18 positive saturation then clean group
        for (int k = 0; k < 8; k++) feed(1, 16384);
        chk("t2_sum", 1, o_sum[1],           131071);
        chk("t2_sat", 1, longint'(o_sat[1]), 1);
        for (int k = 0; k < 8; k++) feed(1, 1);
        chk("t2_sum1", 1, o_sum[1],           8);
        chk("t2_sat1", 1, longint'(o_sat[1]), 0);
        for (int k = 0; k < 8; k++) feed(1, -32768);
        chk("t2_neg",  1, o_sum[1],           -131072);
        chk("t2_nsat", 1, longint'(o_sat[1]), 1);
        idle(1);

        // LEN=2 held result and overrun
        rdy[2] = 1'b0;
        feed(2, 10);
        feed(2, 20);
        chk("t3_sum", 2, o_sum[2],           30);
        chk("t3_ov0", 2, longint'(o_ov[2]),  0);
        feed(2, 1);
        feed(2, 2);
        chk("t3_ov1",  2, longint'(o_ov[2]), 1);
        chk("t3_hold", 2, o_sum[2],          30);
        idle(2);
        chk("t3_stable", 2, o_sum[2], 30);
        rdy[2] = 1'b1;
        idle(1);
        chk("t3_drop",   2, longint'(o_vld[2]), 0);
        chk("t3_sticky", 2, longint'(o_ov[2]),  1);

        // LEN=2 completion in the same cycle the pending result is consumed
        rs[2] = 1'b1;
        idle(1);
        rs[2] = 1'b0;
        rdy[2] = 1'b0;
        feed(2, 5);
        feed(2, 6);
        chk("t4_sum11", 2, o_sum[2], 11);
        feed(2, 7);
        rdy[2] = 1'b1;
        feed(2, 8);
        chk("t4_valid", 2, longint'(o_vld[2]), 1);
        chk("t4_sum15", 2, o_sum[2],           15);
        chk("t4_ov",    2, longint'(o_ov[2]),  0);
        idle(1);
        chk("t4_drop",  2, longint'(o_vld[2]), 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
